data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/data_mem_arbiter.sv | 104 ++++++++++
 tb/tb_data_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and burst counter sizing.
package mem_arb_pkg;

    typedef enum logic {
        S_CORE = 1'b0,
        S_HOST = 1'b1
    } owner_e;

    localparam int                     BURST_CNT_W   = 8;
    localparam logic [BURST_CNT_W-1:0] BURST_CNT_MAX = '1;

endpackage

// File: rtl/data_mem_arbiter.sv
// Shares one combinational-read data memory between a core and a host port.
// Ownership alternates between core and host, and the host is forced to yield periodically while the core runs.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32,
    parameter int HOST_BURST_P      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_run,
    output logic                         o_core_enable,
    input  logic                         i_core_mem_wr_en,
    input  logic [DATA_ADDR_WIDTH_P-1:0] i_core_mem_addr,
    input  logic [DATA_WIDTH_P-1:0]      i_core_mem_wr_data,
    output logic [DATA_WIDTH_P-1:0]      o_core_mem_rd_data,
    input  logic                         i_host_valid,
    input  logic                         i_host_wr,
    input  logic [DATA_ADDR_WIDTH_P-1:0] i_host_addr,
    input  logic [DATA_WIDTH_P-1:0]      i_host_wr_data,
    output logic                         o_host_ready,
    output logic                         o_host_rd_valid,
    output logic [DATA_WIDTH_P-1:0]      o_host_rd_data,
    output logic                         o_mem_wr_en,
    output logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr,
    output logic [DATA_WIDTH_P-1:0]      o_mem_wr_data,
    input  logic [DATA_WIDTH_P-1:0]      i_mem_rd_data,
    output logic                         dbg_owner,
    output logic [BURST_CNT_W-1:0]       dbg_burst_cnt
);

    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(HOST_BURST_P - 1);

    owner_e                   owner_q;
    logic [BURST_CNT_W-1:0]   burst_cnt_q;
    logic                     rd_valid_q;
    logic [DATA_WIDTH_P-1:0]  rd_data_q;

    logic host_rd_accept;
    logic forced_yield;

    // Host handshake: a request transfers on any cycle where valid and ready are both high.
    // Ready is only offered while the host owns the port.
    always_comb begin
        o_core_enable  = i_run && (owner_q == S_CORE) && !reset;
        o_host_ready   = (owner_q == S_HOST) && i_host_valid && !reset;
        host_rd_accept = o_host_ready && !i_host_wr;
        forced_yield   = i_run && (burst_cnt_q == BURST_LAST);

        if (owner_q == S_HOST) begin
            o_mem_wr_en   = i_host_valid && i_host_wr && !reset;
            o_mem_addr    = i_host_addr;
            o_mem_wr_data = i_host_wr_data;
        end else begin
            o_mem_wr_en   = i_core_mem_wr_en && o_core_enable;
            o_mem_addr    = i_core_mem_addr;
            o_mem_wr_data = i_core_mem_wr_data;
        end
    end

    assign o_core_mem_rd_data = i_mem_rd_data;
    assign o_host_rd_valid    = rd_valid_q;
    assign o_host_rd_data     = rd_data_q;
    assign dbg_owner          = owner_q;
    assign dbg_burst_cnt      = burst_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= S_CORE;
            burst_cnt_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_valid_q <= host_rd_accept;
            if (host_rd_accept) begin
                rd_data_q <= i_mem_rd_data;
            end

            case (owner_q)
                S_CORE: begin
                    // The handover is registered, so the host always waits one core cycle.
                    if (i_host_valid) begin
                        owner_q <= S_HOST;
                    end
                    burst_cnt_q <= '0;
                end
                S_HOST: begin
                    if (!i_host_valid || forced_yield) begin
                        owner_q     <= S_CORE;
                        burst_cnt_q <= '0;
                    end else if (burst_cnt_q != BURST_CNT_MAX) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                end
                default: begin
                    owner_q     <= S_CORE;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural memory, a stepping core model
// and a queue of expected host read responses.
module tb_data_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_run;
    logic          o_core_enable;
    logic          i_core_mem_wr_en;
    logic [AW-1:0] i_core_mem_addr;
    logic [DW-1:0] i_core_mem_wr_data;
    logic [DW-1:0] o_core_mem_rd_data;
    logic          i_host_valid;
    logic          i_host_wr;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_wr_data;
    logic          o_host_ready;
    logic          o_host_rd_valid;
    logic [DW-1:0] o_host_rd_data;
    logic          o_mem_wr_en;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wr_data;
    logic [DW-1:0] i_mem_rd_data;
    logic          dbg_owner;
    logic [7:0]    dbg_burst_cnt;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DATA_WIDTH_P      (DW),
        .DATA_ADDR_WIDTH_P (AW),
        .HOST_BURST_P      (BURST)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_run              (i_run),
        .o_core_enable      (o_core_enable),
        .i_core_mem_wr_en   (i_core_mem_wr_en),
        .i_core_mem_addr    (i_core_mem_addr),
        .i_core_mem_wr_data (i_core_mem_wr_data),
        .o_core_mem_rd_data (o_core_mem_rd_data),
        .i_host_valid       (i_host_valid),
        .i_host_wr          (i_host_wr),
        .i_host_addr        (i_host_addr),
        .i_host_wr_data     (i_host_wr_data),
        .o_host_ready       (o_host_ready),
        .o_host_rd_valid    (o_host_rd_valid),
        .o_host_rd_data     (o_host_rd_data),
        .o_mem_wr_en        (o_mem_wr_en),
        .o_mem_addr         (o_mem_addr),
        .o_mem_wr_data      (o_mem_wr_data),
        .i_mem_rd_data      (i_mem_rd_data),
        .dbg_owner          (dbg_owner),
        .dbg_burst_cnt      (dbg_burst_cnt)
    );

    // Behavioural memory: combinational read, write on the rising edge.
    assign i_mem_rd_data = mem[o_mem_addr[7:0]];
    always @(posedge clk) begin
        if (o_mem_wr_en) mem[o_mem_addr[7:0]] <= o_mem_wr_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; returns the number of cycles spent waiting.
    task automatic host_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW-1:0] exp_rd, output int waits);
        bit done;
        done         = 1'b0;
        waits        = 0;
        i_host_valid = 1'b1;
        i_host_wr    = wr;
        i_host_addr  = addr;
        i_host_wr_data = data;
        while (!done && waits < 20) begin
            @(negedge clk);
            if (o_host_ready) begin
                if (!wr) exp_q.push_back(exp_rd);
                done = 1'b1;
            end else begin
                waits++;
            end
            step();
        end
        if (!done) check("host_xfer_timeout", 64'(waits), 64'd0);
    endtask

    always @(negedge clk) begin
        if (o_host_rd_valid) begin
            if (exp_q.size() == 0) check("rd_valid_unexpected", 64'(o_host_rd_valid), 64'd0);
            else check("rd_data_scoreboard", 64'(o_host_rd_data), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int k;
        bit exp_core;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset with every request input active: no enables may leak out.
        reset = 1'b1; i_run = 1'b1; i_host_valid = 1'b1; i_host_wr = 1'b1;
        i_host_addr = 32'h30; i_host_wr_data = 32'h99;
        i_core_mem_wr_en = 1'b1; i_core_mem_addr = 32'h31; i_core_mem_wr_data = 32'h98;
        step();
        check("rst_core_enable", 64'(o_core_enable), 64'd0);
        check("rst_host_ready",  64'(o_host_ready),  64'd0);
        check("rst_mem_wr_en",   64'(o_mem_wr_en),   64'd0);
        step();
        reset = 1'b0; i_run = 1'b0; i_host_valid = 1'b0; i_host_wr = 1'b0; i_core_mem_wr_en = 1'b0;
        check("rst_rd_valid",  64'(o_host_rd_valid), 64'd0);
        check("rst_rd_data",   64'(o_host_rd_data),  64'd0);
        check("rst_owner",     64'(dbg_owner),       64'd0);
        check("rst_burst_cnt", 64'(dbg_burst_cnt),   64'd0);
        check("rst_mem_30",    64'(mem[8'h30]),      64'd0);

        // Core alone: store 7 to address 84.
        i_run = 1'b1; i_core_mem_wr_en = 1'b1; i_core_mem_addr = 32'd84; i_core_mem_wr_data = 32'd7;
        #1;
        check("core_enable",  64'(o_core_enable), 64'd1);
        check("core_wr_en",   64'(o_mem_wr_en),   64'd1);
        check("core_addr",    64'(o_mem_addr),    64'd84);
        step();
        i_core_mem_wr_en = 1'b0;
        check("core_sw_mem84", 64'(mem[84]), 64'd7);
        for (int c = 0; c < 3; c++) begin
            step();
            check("core_enable_idle", 64'(o_core_enable), 64'd1);
        end

        // Host write burst with the core stopped: one wait cycle, then back-to-back.
        i_run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_xfer(1'b1, 32'h10 + 32'(i), 32'hA0 + 32'(i), '0, waits);
            check("wr_burst_waits", 64'(waits), (i == 0) ? 64'd1 : 64'd0);
        end
        i_host_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) check("wr_burst_mem", 64'(mem[8'h10 + i]), 64'hA0 + 64'(i));
        check("owner_back_core", 64'(dbg_owner), 64'd0);

        // Host read of the core-written word.
        host_xfer(1'b0, 32'd84, '0, 32'd7, waits);
        i_host_valid = 1'b0;
        check("rd_waits",       64'(waits),           64'd1);
        check("rd_valid_pulse", 64'(o_host_rd_valid), 64'd1);
        check("rd_data_84",     64'(o_host_rd_data),  64'd7);
        step();
        check("rd_valid_drop",  64'(o_host_rd_valid), 64'd0);
        check("rd_data_hold",   64'(o_host_rd_data),  64'd7);
        host_xfer(1'b0, 32'h12, '0, 32'hA2, waits);
        i_host_valid = 1'b0;
        check("rd_data_12",     64'(o_host_rd_data),  64'hA2);
        step();

        // Core keeps requesting a write while the host owns the port.
        i_core_mem_wr_en = 1'b1; i_core_mem_addr = 32'd200; i_core_mem_wr_data = 32'hDEAD;
        host_xfer(1'b1, 32'h20, 32'h55, '0, waits);
        host_xfer(1'b0, 32'h20, '0, 32'h55, waits);
        i_host_valid = 1'b0; i_core_mem_wr_en = 1'b0;
        step();
        check("host_wr_mem20",   64'(mem[8'h20]), 64'h55);
        check("core_blocked_200", 64'(mem[200]),  64'd0);

        // Core running against continuous host reads: 4 host cycles, 1 core cycle.
        i_run = 1'b1; k = 0;
        i_host_valid = 1'b1; i_host_wr = 1'b0;
        for (int t = 0; t < 40; t++) begin
            i_core_mem_wr_en   = (k < 8);
            i_core_mem_addr    = 32'd100 + 32'(k);
            i_core_mem_wr_data = 32'(k * 3 + 1);
            i_host_addr        = 32'h10 + 32'(t % 4);
            exp_core           = ((t % 5) == 0);
            @(negedge clk);
            check("yield_core_enable", 64'(o_core_enable), 64'(exp_core));
            check("yield_host_ready",  64'(o_host_ready),  64'(!exp_core));
            if (o_host_ready) begin
                check("host_rd_no_wr", 64'(o_mem_wr_en), 64'd0);
                exp_q.push_back(32'hA0 + 32'(t % 4));
            end
            if (o_core_enable) k++;
            step();
        end
        i_host_valid = 1'b0; i_core_mem_wr_en = 1'b0;
        step();
        check("core_steps", 64'(k), 64'd8);
        for (int j = 0; j < 8; j++) check("core_prog_mem", 64'(mem[100 + j]), 64'(j * 3 + 1));

        // Reset in the middle of a host read burst.
        i_run = 1'b0; i_host_valid = 1'b1; i_host_wr = 1'b0; i_host_addr = 32'h13;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (o_host_ready) exp_q.push_back(32'hA3);
            step();
        end
        check("mid_burst_cnt",   64'(dbg_burst_cnt), 64'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_ready",   64'(o_host_ready), 64'd0);
        step();
        check("mid_rst_owner",   64'(dbg_owner),       64'd0);
        check("mid_rst_cnt",     64'(dbg_burst_cnt),   64'd0);
        check("mid_rst_rdvalid", 64'(o_host_rd_valid), 64'd0);
        check("mid_rst_rddata",  64'(o_host_rd_data),  64'd0);
        reset = 1'b0; i_host_valid = 1'b0;
        step();
        check("post_rst_rdvalid", 64'(o_host_rd_valid), 64'd0);
        step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
